char_fetch_arbiter: RTL and testbench

Sequences the per-frame character-buffer refill and arbitrates the single synchronous memory read port between the CPU and the VGA character fetch. On each frame-start pulse it streams `BUF_WORDS` consecutive words from `CHAR_BASE` into the display character buffer. It interleaves those fetches with CPU reads under a bounded-starvation priority rule, and tags every in-flight read so each return reaches its owner. It sits between the CPU load path, the memory read port and the VGA draw logic, and replaces the free-running slow-clock fetch.

---
 rtl/char_fetch_arbiter_if.sv | 36 +++
 rtl/char_fetch_arbiter.sv | 175 +++++++++++++++++
 tb/tb_char_fetch_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/char_fetch_arbiter_if.sv
// char_fetch_arbiter_if: CPU read request/response channel plus the single
// synchronous memory read port.
// Ports (signals):
//   cpu_req, cpu_addr          CPU read request, held until granted
//   cpu_gnt                    combinational grant
//   cpu_rdata, cpu_rvalid      CPU read return
//   mem_re, mem_addr           registered memory read command
//   mem_rdata                  memory read data, MEM_LATENCY after mem_re
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (CPU and memory)
interface char_fetch_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORD_SIZE  = 32
) ();

  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_gnt;
  logic [WORD_SIZE-1:0]  cpu_rdata;
  logic                  cpu_rvalid;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, mem_re, mem_addr
  );

  modport master (
    output cpu_req, cpu_addr, mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, mem_re, mem_addr
  );

endinterface

// File: rtl/char_fetch_arbiter.sv
// char_fetch_arbiter: on each frame_start, streams BUF_WORDS words from
// CHAR_BASE into the display character buffer, sharing the one memory read
// port with CPU loads under a bounded-starvation priority rule. Every issued
// read carries a tag so its return goes to exactly one owner, in issue order.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             CPU request/response and memory read port (slave view)
//   frame_start     one-cycle pulse at vertical blank start
//   vga_wvalid      character-buffer write strobe
//   vga_widx        character-buffer word index
//   vga_wdata       character-buffer word (first character in the MSBs)
//   fetch_busy      high while a frame refill is in progress
//   frame_done      pulse with the last buffer write of a frame
//   overrun         pulse when frame_start arrives during a refill
module char_fetch_arbiter #(
  parameter int unsigned           WORD_SIZE    = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] CHAR_BASE    = '0,
  parameter int unsigned           BUF_WORDS    = 1200,
  parameter int unsigned           MEM_LATENCY  = 1,
  parameter int unsigned           STARVE_LIMIT = 4,
  localparam int unsigned          IDX_W        = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  char_fetch_arbiter_if.slave  bus,
  input  logic                 frame_start,
  output logic                 vga_wvalid,
  output logic [IDX_W-1:0]     vga_widx,
  output logic [WORD_SIZE-1:0] vga_wdata,
  output logic                 fetch_busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned CNT_W = $clog2(BUF_WORDS + 1);
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(BUF_WORDS);
  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(BUF_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BUF_WORDS - 1);
  localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic             vga;
    logic [IDX_W-1:0] idx;
  } tag_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] issue_q;
  logic [STV_W-1:0] starve_q;
  logic             vga_pend;
  logic             cpu_win;
  logic             vga_win;
  tag_t             tag_q [MEM_LATENCY+1];
  tag_t             ret;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration and next state
  always_comb begin
    state_d  = state_q;
    vga_pend = 1'b0;
    cpu_win  = 1'b0;
    vga_win  = 1'b0;

    if (state_q == FETCH) begin
      vga_pend = (issue_q < CNT_END);
    end
    cpu_win = bus.cpu_req && (!vga_pend || (starve_q < STV_MAX));
    vga_win = vga_pend && !cpu_win;

    unique case (state_q)
      IDLE:    if (frame_start) state_d = FETCH;
      FETCH:   if (vga_win && (issue_q == LAST_ISSUE)) state_d = DRAIN;
      // frame_done is high while the last return is written; leave next cycle
      DRAIN:   if (frame_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is forced low while reset is asserted
  assign bus.cpu_gnt = cpu_win & rst_n;
  assign fetch_busy  = (state_q != IDLE);

  // Issue and starvation counters, cleared whenever idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      issue_q  <= '0;
      starve_q <= '0;
    end else if (vga_win) begin
      issue_q  <= issue_q + CNT_W'(1);
      starve_q <= '0;
    end else if (cpu_win && vga_pend && (starve_q < STV_MAX)) begin
      starve_q <= starve_q + STV_W'(1);
    end
  end

  // Memory read command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_re   <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      bus.mem_re <= cpu_win | vga_win;
      if (cpu_win) begin
        bus.mem_addr <= bus.cpu_addr;
      end else if (vga_win) begin
        bus.mem_addr <= CHAR_BASE + ADDR_WIDTH'(issue_q);
      end
    end
  end

  // Tag pipeline: stage k lines up with the read issued k cycles ago
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i <= MEM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: cpu_win | vga_win,
                    vga:   vga_win,
                    idx:   vga_win ? IDX_W'(issue_q) : '0};
      for (int unsigned i = 1; i <= MEM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign ret = tag_q[MEM_LATENCY];

  // Return routing: mem_rdata is valid exactly when the last tag stage is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      vga_wvalid     <= 1'b0;
      vga_widx       <= '0;
      vga_wdata      <= '0;
      frame_done     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      bus.cpu_rvalid <= ret.valid & ~ret.vga;
      vga_wvalid     <= ret.valid & ret.vga;
      frame_done     <= ret.valid & ret.vga & (ret.idx == LAST_IDX);
      overrun        <= frame_start & (state_q != IDLE);
      if (ret.valid && !ret.vga) begin
        bus.cpu_rdata <= bus.mem_rdata;
      end
      if (ret.valid && ret.vga) begin
        vga_widx  <= ret.idx;
        vga_wdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_char_fetch_arbiter.sv
// tb_char_fetch_arbiter: directed and random stimulus against a
// transaction-level reference model of the refill/arbitration rules.
module tb_char_fetch_arbiter;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          BUF  = 8;
  localparam int          LAT  = 1;
  localparam int          LIM  = 4;
  localparam int          IW   = 3;
  localparam int          RET  = 2 + LAT;
  localparam logic [31:0] BASE = 32'h100;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          frame_start = 1'b0;
  logic          vga_wvalid;
  logic [IW-1:0] vga_widx;
  logic [DW-1:0] vga_wdata;
  logic          fetch_busy;
  logic          frame_done;
  logic          overrun;

  char_fetch_arbiter_if #(.ADDR_WIDTH(AW), .WORD_SIZE(DW)) bus ();

  char_fetch_arbiter #(
    .WORD_SIZE   (DW),
    .ADDR_WIDTH  (AW),
    .CHAR_BASE   (BASE),
    .BUF_WORDS   (BUF),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .frame_start(frame_start),
    .vga_wvalid (vga_wvalid),
    .vga_widx   (vga_widx),
    .vga_wdata  (vga_wdata),
    .fetch_busy (fetch_busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // Single-cycle-latency synchronous memory
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem_fn(bus.mem_addr);
  end

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model state
  bit m_active   = 1'b0;
  int m_issued   = 0;
  int m_starve   = 0;
  int m_end      = -1;
  int m_frames   = 0;
  int m_ovr      = 0;
  bit last_cw    = 1'b0;

  // Expected events keyed by cycle number
  bit          e_re   [int];
  logic [31:0] e_addr [int];
  bit          e_crv  [int];
  logic [31:0] e_cdat [int];
  bit          e_vwv  [int];
  int          e_widx [int];
  logic [31:0] e_wdat [int];
  bit          e_done [int];
  bit          e_ovr  [int];

  // Observed statistics
  int obs_vwv, obs_crv, obs_done, obs_ovr, obs_vga_iss;
  int last_done_cyc, first_re_cyc;
  int next_widx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic reset_stats();
    obs_vwv = 0; obs_crv = 0; obs_done = 0; obs_ovr = 0; obs_vga_iss = 0;
    last_done_cyc = -1; first_re_cyc = -1;
    m_frames = 0; m_ovr = 0;
  endtask

  task automatic clear_model();
    m_active = 1'b0; m_issued = 0; m_starve = 0; m_end = -1; last_cw = 1'b0;
    e_re.delete(); e_addr.delete(); e_crv.delete(); e_cdat.delete();
    e_vwv.delete(); e_widx.delete(); e_wdat.delete(); e_done.delete(); e_ovr.delete();
    next_widx = 0;
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, ":mem_re"},     64'(bus.mem_re),     64'(0));
    chk({ph, ":mem_addr"},   64'(bus.mem_addr),   64'(0));
    chk({ph, ":cpu_gnt"},    64'(bus.cpu_gnt),    64'(0));
    chk({ph, ":cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'(0));
    chk({ph, ":cpu_rdata"},  64'(bus.cpu_rdata),  64'(0));
    chk({ph, ":vga_wvalid"}, 64'(vga_wvalid),     64'(0));
    chk({ph, ":vga_widx"},   64'(vga_widx),       64'(0));
    chk({ph, ":vga_wdata"},  64'(vga_wdata),      64'(0));
    chk({ph, ":fetch_busy"}, 64'(fetch_busy),     64'(0));
    chk({ph, ":frame_done"}, 64'(frame_done),     64'(0));
    chk({ph, ":overrun"},    64'(overrun),        64'(0));
  endtask

  task automatic check_outputs(input int c);
    bit x;
    x = e_re.exists(c) != 0;
    chk("mem_re", 64'(bus.mem_re), 64'(x));
    if (x) chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr[c]));
    x = e_crv.exists(c) != 0;
    chk("cpu_rvalid", 64'(bus.cpu_rvalid), 64'(x));
    if (x) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e_cdat[c]));
    x = e_vwv.exists(c) != 0;
    chk("vga_wvalid", 64'(vga_wvalid), 64'(x));
    if (x) begin
      chk("vga_widx", 64'(vga_widx), 64'(e_widx[c]));
      chk("vga_wdata", 64'(vga_wdata), 64'(e_wdat[c]));
    end
    x = e_done.exists(c) != 0;
    chk("frame_done", 64'(frame_done), 64'(x));
    x = e_ovr.exists(c) != 0;
    chk("overrun", 64'(overrun), 64'(x));
    chk("fetch_busy", 64'(fetch_busy), 64'(m_active));

    if (vga_wvalid) begin
      obs_vwv++;
      chk("widx_order", 64'(vga_widx), 64'(next_widx));
      next_widx = (next_widx + 1) % BUF;
    end
    if (bus.cpu_rvalid) obs_crv++;
    if (frame_done) begin
      obs_done++;
      last_done_cyc = c;
    end
    if (overrun) obs_ovr++;
    if (bus.mem_re) begin
      if (first_re_cyc < 0) first_re_cyc = c;
      if (bus.mem_addr >= BASE && bus.mem_addr < BASE + 32'(BUF)) obs_vga_iss++;
    end
  endtask

  // One cycle of the reference rules: who owns the port, what comes back when
  task automatic model_step(input int c, input logic req, input logic [31:0] addr,
                            input logic fs);
    bit          vpend, cw, vw;
    logic [31:0] a;
    vpend = m_active && (m_issued < BUF);
    cw    = req && (!vpend || (m_starve < LIM));
    vw    = vpend && !cw;
    chk("cpu_gnt", 64'(bus.cpu_gnt), 64'(cw));
    last_cw = cw;
    if (cw) begin
      e_re[c+1]     = 1'b1;
      e_addr[c+1]   = addr;
      e_crv[c+RET]  = 1'b1;
      e_cdat[c+RET] = mem_fn(addr);
    end
    if (vw) begin
      a             = BASE + 32'(m_issued);
      e_re[c+1]     = 1'b1;
      e_addr[c+1]   = a;
      e_vwv[c+RET]  = 1'b1;
      e_widx[c+RET] = m_issued;
      e_wdat[c+RET] = mem_fn(a);
      if (m_issued == BUF - 1) begin
        e_done[c+RET] = 1'b1;
        m_end         = c + RET;
      end
      m_issued++;
      m_starve = 0;
    end else if (cw && vpend && (m_starve < LIM)) begin
      m_starve++;
    end
    if (fs && m_active) begin
      e_ovr[c+1] = 1'b1;
      m_ovr++;
    end
    if (m_active && c == m_end) begin
      m_active = 1'b0;
    end else if (!m_active && fs) begin
      m_active = 1'b1;
      m_issued = 0;
      m_starve = 0;
      m_end    = -1;
      m_frames++;
    end
  endtask

  task automatic step(input logic req, input logic [31:0] addr, input logic fs);
    @(posedge clk);
    cyc++;
    #1;
    check_outputs(cyc);
    bus.cpu_req  = req;
    bus.cpu_addr = addr;
    frame_start  = fs;
    #1;
    model_step(cyc, req, addr, fs);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int          c0;
    logic [31:0] a;
    logic        rq;
    logic        fs;

    // Power-on reset with a request pending: everything, grant included, stays 0
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h55;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_zero("por");
    end
    bus.cpu_req = 1'b0;
    rst_n       = 1'b1;
    clear_model();

    // Idle CPU read: grant same cycle, address next, data 3 cycles later
    reset_stats();
    repeat (4) step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h20, 1'b0);
    repeat (5) step(1'b0, 32'h0, 1'b0);
    chk("idle_crv_count", 64'(obs_crv), 64'(1));

    // VGA-only frame
    reset_stats();
    step(1'b0, 32'h0, 1'b1);
    c0 = cyc;
    repeat (16) step(1'b0, 32'h0, 1'b0);
    chk("vga_writes", 64'(obs_vwv), 64'(BUF));
    chk("vga_done_count", 64'(obs_done), 64'(1));
    chk("vga_done_latency", 64'(last_done_cyc - c0), 64'(11));
    chk("vga_first_issue", 64'(first_re_cyc - c0), 64'(2));

    // Starvation bound: CPU requests continuously across a whole frame
    reset_stats();
    a = 32'h4000;
    step(1'b1, a, 1'b1);
    repeat (52) begin
      if (last_cw) a = a + 32'h1;
      step(1'b1, a, 1'b0);
    end
    repeat (6) step(1'b0, 32'h0, 1'b0);
    chk("starve_vga_issues", 64'(obs_vga_iss), 64'(BUF));
    chk("starve_done_count", 64'(obs_done), 64'(1));
    chk("starve_writes", 64'(obs_vwv), 64'(BUF));

    // Overrun: second frame_start while word 3 is being issued
    reset_stats();
    step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    repeat (14) step(1'b0, 32'h0, 1'b0);
    chk("ovr_count", 64'(obs_ovr), 64'(1));
    chk("ovr_writes", 64'(obs_vwv), 64'(BUF));
    chk("ovr_done_count", 64'(obs_done), 64'(1));

    // Reset mid-FETCH with two reads in flight
    step(1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    rst_n        = 1'b0;
    bus.cpu_req  = 1'b1;
    frame_start  = 1'b0;
    #1;
    chk_zero("rst_mid");
    repeat (3) begin
      @(posedge clk);
      cyc++;
      #1;
      chk_zero("rst_mid");
    end
    bus.cpu_req = 1'b0;
    rst_n       = 1'b1;
    clear_model();
    reset_stats();
    repeat (5) step(1'b0, 32'h0, 1'b0);
    chk("post_rst_strobes", 64'(obs_vwv + obs_crv), 64'(0));
    step(1'b0, 32'h0, 1'b1);
    repeat (14) step(1'b0, 32'h0, 1'b0);
    chk("post_rst_writes", 64'(obs_vwv), 64'(BUF));
    chk("post_rst_done", 64'(obs_done), 64'(1));

    // Mixed random traffic, with occasional (sometimes overrunning) frames
    reset_stats();
    rq = 1'b0;
    a  = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!rq && ($urandom_range(0, 1) == 1)) begin
        rq = 1'b1;
        a  = $urandom;
      end
      fs = ($urandom_range(0, 29) == 0);
      step(rq, a, fs);
      if (last_cw) rq = 1'b0;
    end
    repeat (20) step(1'b0, 32'h0, 1'b0);
    chk("mix_frames_done", 64'(obs_done), 64'(m_frames));
    chk("mix_overruns", 64'(obs_ovr), 64'(m_ovr));
    chk("mix_writes", 64'(obs_vwv), 64'(m_frames * BUF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
